// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller.
// Serializes a parallel word LSB-first at one bit per baud clock and drives the
// selector, data bit and parity bit of the downstream TX output mux.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [2:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    // Counter value of the last DATA cycle; the frame leaves DATA here, so the
    // counter never needs to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Encodings double as the mux selector value.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  accept;

    // Next-state, datapath and acceptance logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        // A new word is only taken when the line is idle or finishing a frame,
        // which gives back-to-back frames without queuing anything mid-frame.
        accept = data_valid && ((state_q == S_IDLE) || (state_q == S_STOP));

        if (accept) begin
            shift_d   = p_data;
            par_en_d  = par_en;
            par_bit_d = par_typ ? ~^p_data : ^p_data;
            cnt_d     = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                state_d = accept ? S_START : S_IDLE;
            end
            default: begin
                // Unreachable encodings fall back to idle.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, dropping any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
        end
    end

    assign mux_sel  = state_q;
    assign busy     = (state_q != S_IDLE);
    assign ser_data = shift_q[0];
    assign par_bit  = par_bit_q;

endmodule
